// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
package regfile_pkg;

  localparam int unsigned RF_DW    = 32;
  localparam int unsigned RF_DEPTH = 32;
  localparam int unsigned RF_AW    = 5;
  localparam int unsigned RF_NW    = 2;
  localparam int unsigned RF_NR    = 2;

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0] rf_data_t;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy flags for pending long-latency results, plus busy read muxes.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = RF_DEPTH,
  parameter int unsigned NR    = RF_NR,
  parameter int unsigned AW    = RF_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] set_vec,
  input  logic [DEPTH-1:0] clr_vec,
  input  logic [NR-1:0]    re,
  input  logic [NR*AW-1:0] raddr,
  output logic [NR-1:0]    rbusy
);

  logic [DEPTH-1:0] busy_q;

  // A new issue wins over a same-cycle completion clearing the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= set_vec | (busy_q & ~clr_vec);
    end
  end

  for (genvar j = 0; j < NR; j++) begin : g_rd
    assign rbusy[j] = re[j] & busy_q[raddr[j*AW +: AW]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with busy scoreboard; write port 0 has priority.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DW      = RF_DW,
  parameter int unsigned DEPTH   = RF_DEPTH,
  parameter int unsigned NW      = RF_NW,
  parameter int unsigned NR      = RF_NR,
  parameter bit          ZERO_R0 = 1'b1,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] waddr,
  input  logic [NW*DW-1:0] wdata,
  input  logic [NW-1:0]    wclr,
  input  logic             sb_set,
  input  logic [AW-1:0]    sb_addr,
  input  logic [NR-1:0]    re,
  input  logic [NR*AW-1:0] raddr,
  output logic [NR*DW-1:0] rdata,
  output logic [NR-1:0]    rbusy
);

  logic [DEPTH-1:0]    wsel;
  logic [DEPTH-1:0]    clr_vec;
  logic [DEPTH-1:0]    set_vec;
  logic [DEPTH*DW-1:0] wval;
  logic [NR-1:0]       sb_rbusy;
  logic [DW-1:0]       mem [DEPTH];

  // Per-register priority select: scanning down so the lowest port index lands last.
  for (genvar r = 0; r < DEPTH; r++) begin : g_wsel
    localparam bit DROP = ZERO_R0 && (r == 0);
    logic          sel;
    logic          clr;
    logic [DW-1:0] val;

    always_comb begin
      sel = 1'b0;
      clr = 1'b0;
      val = '0;
      for (int i = NW - 1; i >= 0; i--) begin
        if (we[i] && (waddr[i*AW +: AW] == AW'(r))) begin
          sel = 1'b1;
          val = wdata[i*DW +: DW];
          if (wclr[i]) clr = 1'b1;
        end
      end
    end

    assign wsel[r]           = sel & ~DROP;
    assign clr_vec[r]        = clr & ~DROP;
    assign set_vec[r]        = sb_set & (sb_addr == AW'(r)) & ~DROP;
    assign wval[r*DW +: DW]  = val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wsel[r]) mem[r] <= wval[r*DW +: DW];
      end
    end
  end

  rf_scoreboard #(
    .DEPTH (DEPTH),
    .NR    (NR),
    .AW    (AW)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_vec (set_vec),
    .clr_vec (clr_vec),
    .re      (re),
    .raddr   (raddr),
    .rbusy   (sb_rbusy)
  );

  for (genvar j = 0; j < NR; j++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic          bz;

    assign ra = raddr[j*AW +: AW];

    always_comb begin
      rd = mem[ra];
      bz = sb_rbusy[j];
`ifdef REGFILE_BYPASS_EN
      if (wsel[ra]) rd = wval[32'(ra)*DW +: DW];
      if (clr_vec[ra]) bz = 1'b0;
`endif
      // Disabled ports and a hardwired x0 read as idle zero.
      if (!re[j] || (ZERO_R0 && (ra == '0))) begin
        rd = '0;
        bz = 1'b0;
      end
    end

    assign rdata[j*DW +: DW] = rd;
    assign rbusy[j]          = bz;
  end

endmodule
